// File: rtl/writing_address_trace_debugger_pkg.sv
`default_nettype none
// ============================================================================
// writing_address_trace_debugger_pkg: register map and bit positions shared
// by the trace debugger and its FIFO.  Rev 1.0
// ============================================================================
package writing_address_trace_debugger_pkg;

  localparam int AVALON_DATA_W = 64;
  localparam int AVALON_ADDR_W = 2;

  localparam logic [AVALON_ADDR_W-1:0] ADDR_TRACE  = 2'd0;
  localparam logic [AVALON_ADDR_W-1:0] ADDR_PART   = 2'd1;
  localparam logic [AVALON_ADDR_W-1:0] ADDR_STATUS = 2'd2;
  localparam logic [AVALON_ADDR_W-1:0] ADDR_CTRL   = 2'd3;

  localparam int TRACE_VALID_BIT     = 63;
  localparam int STATUS_COUNT_LSB    = 0;
  localparam int STATUS_COUNT_W      = 9;
  localparam int STATUS_OVERFLOW_BIT = 16;
  localparam int STATUS_DROPPED_LSB  = 24;
  localparam int STATUS_CAPTURE_BIT  = 32;
  localparam int CTRL_CAPTURE_BIT    = 0;
  localparam int CTRL_CLEAR_BIT      = 1;
  localparam int DROPPED_W           = 8;

  typedef struct packed {
    logic                 capture_en;
    logic                 overflow;
    logic [DROPPED_W-1:0] dropped;
  } dbg_status_t;

  // Saturating increment for the dropped-entry counter.
  function automatic logic [DROPPED_W-1:0] sat_inc(input logic [DROPPED_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writing_address_trace_debugger_trace_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo: show-ahead circular FIFO with synchronous clear.
// Rev 1.0
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty && !clear;
  assign w_do_push = push && (!full || w_do_pop) && !clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/writing_address_trace_debugger.sv
`default_nettype none
// ============================================================================
// writing_address_trace_debugger: timestamps changes of a debug bus into a
// trace FIFO readable over Avalon-MM; also holds partition write enables.
// Rev 1.0
// ============================================================================
module writing_address_trace_debugger
  import writing_address_trace_debugger_pkg::*;
#(
  parameter int DBG_WIDTH      = 5,
  parameter int NUM_PARTITIONS = 5,
  parameter int DEPTH          = 16,
  parameter int TS_WIDTH       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                io_Avalon_address,
  input  logic                      io_Avalon_read,
  input  logic                      io_Avalon_write,
  input  logic [63:0]               io_Avalon_writedata,
  output logic [63:0]               io_Avalon_readdata,
  output logic                      io_Avalon_waitrequest,
  output logic [NUM_PARTITIONS-1:0] io_PartitionWriteEnables,
  input  logic [DBG_WIDTH-1:0]      io___dbgInfo
);

  localparam int ENTRY_W = TS_WIDTH + DBG_WIDTH;
  localparam int CNT_W   = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic [TS_WIDTH-1:0]       r_timestamp;
  logic [DBG_WIDTH-1:0]      r_prev_dbg;
  logic [NUM_PARTITIONS-1:0] r_part_en;
  dbg_status_t               r_status;

  logic               w_change;
  logic               w_push_req;
  logic               w_pop;
  logic               w_drop;
  logic               w_ctrl_write;
  logic               w_part_write;
  logic               w_clear;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic [63:0]        w_readdata;
  logic               w_unused_wdata;

  assign w_change     = (io___dbgInfo != r_prev_dbg);
  assign w_push_req   = w_change && r_status.capture_en;
  assign w_pop        = io_Avalon_read && (io_Avalon_address == ADDR_TRACE) && !w_empty;
  assign w_drop       = w_push_req && w_full && !w_pop;
  assign w_ctrl_write = io_Avalon_write && (io_Avalon_address == ADDR_CTRL);
  assign w_part_write = io_Avalon_write && (io_Avalon_address == ADDR_PART);
  assign w_clear      = w_ctrl_write && io_Avalon_writedata[CTRL_CLEAR_BIT];

  // Only the low bits of writedata are meaningful at any address.
  assign w_unused_wdata = ^io_Avalon_writedata;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push_req && !w_drop),
    .push_data ({r_timestamp, io___dbgInfo}),
    .pop       (w_pop),
    .clear     (w_clear),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head_data (w_head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timestamp <= '0;
      r_prev_dbg  <= '0;
      r_part_en   <= '0;
    end else begin
      r_timestamp <= r_timestamp + TS_WIDTH'(1);
      if (w_change)     r_prev_dbg <= io___dbgInfo;
      if (w_part_write) r_part_en  <= io_Avalon_writedata[NUM_PARTITIONS-1:0];
    end
  end

  // Clear outranks a same-cycle drop so software always sees a clean slate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status.capture_en <= 1'b1;
      r_status.overflow   <= 1'b0;
      r_status.dropped    <= '0;
    end else begin
      if (w_ctrl_write) r_status.capture_en <= io_Avalon_writedata[CTRL_CAPTURE_BIT];
      if (w_clear) begin
        r_status.overflow <= 1'b0;
        r_status.dropped  <= '0;
      end else if (w_drop) begin
        r_status.overflow <= 1'b1;
        r_status.dropped  <= sat_inc(r_status.dropped);
      end
    end
  end

  always_comb begin
    w_readdata = '0;
    case (io_Avalon_address)
      ADDR_TRACE: begin
        if (!w_empty) begin
          w_readdata[TRACE_VALID_BIT] = 1'b1;
          w_readdata[ENTRY_W-1:0]     = w_head;
        end
      end
      ADDR_PART: begin
        w_readdata[NUM_PARTITIONS-1:0] = r_part_en;
      end
      ADDR_STATUS: begin
        w_readdata[STATUS_COUNT_LSB +: CNT_W]      = w_count;
        w_readdata[STATUS_OVERFLOW_BIT]            = r_status.overflow;
        w_readdata[STATUS_DROPPED_LSB +: DROPPED_W] = r_status.dropped;
        w_readdata[STATUS_CAPTURE_BIT]             = r_status.capture_en;
      end
      ADDR_CTRL: begin
        w_readdata[CTRL_CAPTURE_BIT] = r_status.capture_en;
      end
      default: begin
        w_readdata = '0;
      end
    endcase
  end

  assign io_Avalon_readdata       = w_readdata;
  assign io_Avalon_waitrequest    = 1'b0;
  assign io_PartitionWriteEnables = r_part_en;

endmodule
`default_nettype wire

// File: tb/tb_writing_address_trace_debugger.sv
`default_nettype none
// ============================================================================
// tb_writing_address_trace_debugger: table vectors, directed corner cases and
// random traffic against a queue-based reference model.  Rev 1.0
// ============================================================================
module tb_writing_address_trace_debugger;

  localparam int DBG_WIDTH      = 5;
  localparam int NUM_PARTITIONS = 5;
  localparam int DEPTH          = 16;
  localparam int TS_WIDTH       = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [63:0] writedata = '0;
  logic [63:0] readdata;
  logic        waitrequest;
  logic [NUM_PARTITIONS-1:0] part;
  logic [DBG_WIDTH-1:0]      dbg = '0;

  writing_address_trace_debugger #(
    .DBG_WIDTH      (DBG_WIDTH),
    .NUM_PARTITIONS (NUM_PARTITIONS),
    .DEPTH          (DEPTH),
    .TS_WIDTH       (TS_WIDTH)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_Avalon_address        (address),
    .io_Avalon_read           (read),
    .io_Avalon_write          (write),
    .io_Avalon_writedata      (writedata),
    .io_Avalon_readdata       (readdata),
    .io_Avalon_waitrequest    (waitrequest),
    .io_PartitionWriteEnables (part),
    .io___dbgInfo             (dbg)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [20:0] m_q[$];
  logic        m_cap;
  logic        m_ovf;
  int          m_drop;
  logic [4:0]  m_part;
  logic [4:0]  m_prev;
  logic [15:0] m_ts;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  a;
    logic [63:0] wd;
    logic [4:0]  d;
    bit          chk;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_cap  = 1'b1;
    m_ovf  = 1'b0;
    m_drop = 0;
    m_part = '0;
    m_prev = '0;
    m_ts   = '0;
  endfunction

  function automatic logic [63:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return (m_q.size() > 0) ? {1'b1, 42'b0, m_q[0]} : 64'd0;
      2'd1:    return 64'(m_part);
      2'd2:    return 64'(m_q.size()) | (64'(m_ovf) << 16) | (64'(m_drop) << 24) | (64'(m_cap) << 32);
      default: return 64'(m_cap);
    endcase
  endfunction

  function automatic void model_step(input logic rd, input logic wr, input logic [1:0] a,
                                     input logic [63:0] wd, input logic [4:0] d);
    bit was_full;
    bit pop;
    bit change;
    was_full = (m_q.size() >= DEPTH);
    pop      = rd && (a == 2'd0) && (m_q.size() > 0);
    change   = (d != m_prev);
    if (wr && a == 2'd3 && wd[1]) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (change && m_cap) begin
        if (!was_full || pop) m_q.push_back({m_ts, d});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (wr && a == 2'd3) m_cap = wd[0];
    if (wr && a == 2'd1) m_part = wd[4:0];
    if (change) m_prev = d;
    m_ts = m_ts + 16'd1;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic rd, input logic wr, input logic [1:0] a,
                       input logic [63:0] wd, input logic [4:0] d,
                       input bit chk = 1'b0, input logic [63:0] exp = 64'd0,
                       input string name = "vector");
    read = rd; write = wr; address = a; writedata = wd; dbg = d;
    #1;
    check($sformatf("model_readdata_a%0d", a), readdata, model_read(a));
    check("model_part_en", 64'(part), 64'(m_part));
    check("waitrequest", 64'(waitrequest), 64'd0);
    if (chk) check(name, readdata, exp);
    model_step(rd, wr, a, wd, d);
    @(posedge clock);
    #1;
  endtask

  task automatic probe(input logic [1:0] a, input string name, input logic [63:0] exp);
    read = 1'b0; write = 1'b0; address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic apply_reset();
    read = 1'b0; write = 1'b0; address = '0; writedata = '0; dbg = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic void add(input logic rd, input logic wr, input logic [1:0] a,
                              input logic [63:0] wd, input logic [4:0] d,
                              input bit chk, input logic [63:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.d = d; v.chk = chk; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    // Table: vector index equals timestamp after reset release.
    for (int i = 0; i < 10; i++) add(0, 0, 2'd0, 64'd0, 5'd0, 0, 64'd0);
    for (int i = 10; i < 14; i++) add(0, 0, 2'd0, 64'd0, 5'd3, 0, 64'd0);
    add(0, 0, 2'd0, 64'd0, 5'd7, 0, 64'd0);
    add(1, 0, 2'd0, 64'd0, 5'd7, 1, 64'h8000_0000_0000_0143);
    add(1, 0, 2'd0, 64'd0, 5'd7, 1, 64'h8000_0000_0000_01C7);
    add(1, 0, 2'd0, 64'd0, 5'd7, 1, 64'h0);
    add(1, 0, 2'd2, 64'd0, 5'd7, 1, 64'h1_0000_0000);
    add(0, 1, 2'd1, 64'h1F, 5'd7, 0, 64'd0);
    add(1, 0, 2'd1, 64'd0, 5'd7, 1, 64'h1F);
    add(0, 1, 2'd1, 64'hFFFF_FFFF_FFFF_FFE0, 5'd7, 0, 64'd0);
    add(1, 0, 2'd1, 64'd0, 5'd7, 1, 64'h0);
    add(0, 1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 0, 64'd0);
    add(0, 1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 0, 64'd0);
    add(1, 0, 2'd2, 64'd0, 5'd7, 1, 64'h1_0000_0000);
    add(1, 0, 2'd3, 64'd0, 5'd7, 1, 64'h1);

    apply_reset();
    probe(2'd2, "reset_status", 64'h1_0000_0000);
    check("reset_part_en", 64'(part), 64'd0);
    foreach (tbl[i])
      cycle(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].chk, tbl[i].exp,
            $sformatf("table[%0d]", i));

    // Overflow: 20 changes into 16 entries.
    apply_reset();
    for (int i = 0; i < 20; i++) cycle(0, 0, 2'd0, 64'd0, 5'(i + 1));
    probe(2'd2, "overflow_status", 64'h1_0401_0010);
    for (int i = 0; i < 16; i++)
      cycle(1, 0, 2'd0, 64'd0, 5'd20, 1, {1'b1, 42'b0, 16'(i), 5'(i + 1)}, "overflow_drain");
    probe(2'd0, "overflow_empty", 64'd0);

    // Simultaneous push and pop while full.
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(0, 0, 2'd0, 64'd0, 5'(i + 1));
    cycle(1, 0, 2'd0, 64'd0, 5'd17, 1, 64'h8000_0000_0000_0001, "full_pushpop_head");
    probe(2'd2, "full_pushpop_status", 64'h1_0000_0010);
    for (int i = 0; i < 16; i++)
      cycle(1, 0, 2'd0, 64'd0, 5'd17, (i == 15), 64'h8000_0000_0000_0211, "full_pushpop_tail");

    // Capture disable, then clear after overflow.
    apply_reset();
    cycle(0, 1, 2'd3, 64'd0, 5'd0);
    cycle(0, 0, 2'd0, 64'd0, 5'd9);
    cycle(0, 0, 2'd0, 64'd0, 5'd10);
    probe(2'd2, "capture_off_status", 64'h0);
    cycle(0, 1, 2'd3, 64'd1, 5'd10);
    for (int i = 0; i < 18; i++) cycle(0, 0, 2'd0, 64'd0, (i % 2 == 0) ? 5'd21 : 5'd22);
    probe(2'd2, "pre_clear_status", 64'h1_0201_0010);
    cycle(1, 1, 2'd3, 64'd3, 5'd22);
    probe(2'd2, "post_clear_status", 64'h1_0000_0000);

    // Asynchronous reset with entries buffered.
    apply_reset();
    cycle(0, 1, 2'd1, 64'h15, 5'd0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'd0, 64'd0, 5'(i + 1));
    probe(2'd2, "five_buffered", 64'h1_0000_0005);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_status", readdata, 64'h1_0000_0000);
    check("async_reset_part_en", 64'(part), 64'd0);
    check("async_reset_waitreq", 64'(waitrequest), 64'd0);
    @(posedge clock);
    #1;
    check("held_reset_status", readdata, 64'h1_0000_0000);
    check("held_reset_waitreq", 64'(waitrequest), 64'd0);
    reset = 1'b0;
    cycle(0, 0, 2'd0, 64'd0, 5'd6);
    cycle(1, 0, 2'd0, 64'd0, 5'd6, 1, 64'h8000_0000_0000_0006, "post_reset_ts0");

    // Random traffic against the model.
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      logic        rd;
      logic        wr;
      logic [1:0]  a;
      logic [63:0] wd;
      logic [4:0]  d;
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      if (a == 2'd3) begin
        wd[0] = ($urandom_range(0, 7) != 0);
        wd[1] = ($urandom_range(0, 15) == 0);
      end
      d = ($urandom_range(0, 1) == 0) ? 5'($urandom) : dbg;
      cycle(rd, wr, a, wd, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
